// File: rtl/disp_wdata_burst_slicer_pkg.sv
// -----------------------------------------------------------------------------
// disp_wdata_burst_slicer_pkg
//   Shared constants for the display write-data burst slicer.
//   - MAX_BURST_LEN_LIMIT : largest legal MaxBurstLen (AXI-style 256 beats)
//   - BLEN_W              : width of a burst-length record, clog2(256) = 8
//   - REC_FIFO_DEPTH      : number of burst records buffered toward the
//                           address/accounting side
//   - burst_len_legal()   : elaboration-time range check for MaxBurstLen
// -----------------------------------------------------------------------------
package disp_wdata_burst_slicer_pkg;

  localparam int unsigned MAX_BURST_LEN_LIMIT = 256;
  localparam int unsigned BLEN_W              = $clog2(MAX_BURST_LEN_LIMIT);
  localparam int unsigned REC_FIFO_DEPTH      = 2;

  function automatic bit burst_len_legal(input int unsigned len);
    return (len >= 1) && (len <= MAX_BURST_LEN_LIMIT);
  endfunction

endpackage

// File: rtl/disp_wdata_burst_slicer_rec.sv
// -----------------------------------------------------------------------------
// disp_burst_rec_fifo
//   Two-entry first-word-fall-through FIFO for burst-length records. The head
//   entry is a register, so o_valid/o_data come straight from flops and rise
//   the cycle after a push into an empty FIFO.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write side (caller guarantees no push when full
//                     unless a pop happens in the same cycle)
//   o_valid, o_data   registered head entry
//   i_ready           consumer accepts head when o_valid && i_ready
//   o_count           occupancy, 0..2
// -----------------------------------------------------------------------------
module disp_burst_rec_fifo
  import disp_wdata_burst_slicer_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count
);

  logic [Width-1:0] r_head;
  logic [Width-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign w_pop = (r_cnt != 2'd0) && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_data;
          else               r_tail <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          // Tail slides into the head; with one entry the head simply goes
          // invalid and its stale contents are never presented.
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; with one entry the new record replaces the
          // departing head directly.
          if (r_cnt == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_cnt;

  // Depth is fixed at two by the storage above.
  if (REC_FIFO_DEPTH != 2) begin : g_bad_depth
    $error("disp_burst_rec_fifo supports a depth of exactly 2");
  end

endmodule

// File: rtl/disp_wdata_burst_slicer.sv
// -----------------------------------------------------------------------------
// disp_wdata_burst_slicer
//   Consumes the display data driver stream (SDATA/SVALID/SREADY/SLAST) and
//   slices each transfer into write bursts of at most MaxBurstLen beats.
//   WLAST marks every burst end (length limit or transfer end) and one
//   burst-length record (BLEN = beats - 1) is queued per burst.
//
//   The W channel is a registered output stage plus a one-entry skid, so
//   SREADY is a function of flops only (never of WREADY or SVALID).
//
// Ports
//   CLK, RESET                 clock, asynchronous active-high reset
//   SDATA/SVALID/SREADY/SLAST  input beat stream
//   WDATA/WVALID/WREADY/WLAST  registered write-data channel
//   BLEN/BVALID/BREADY         burst-length record channel (FWFT, 2 deep)
//
// Optional build macro DISP_BURST_STAT_EN adds:
//   STAT_BURSTS  saturating count of records pushed
//   STAT_STALL   saturating count of cycles with SVALID && !SREADY
// -----------------------------------------------------------------------------
module disp_wdata_burst_slicer
  import disp_wdata_burst_slicer_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int MaxBurstLen   = 16,
  parameter int BurstLenWidth = BLEN_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DataWidth-1:0]     SDATA,
  input  logic                     SVALID,
  output logic                     SREADY,
  input  logic                     SLAST,
  output logic [DataWidth-1:0]     WDATA,
  output logic                     WVALID,
  input  logic                     WREADY,
  output logic                     WLAST,
  output logic [BurstLenWidth-1:0] BLEN,
  output logic                     BVALID,
  input  logic                     BREADY
`ifdef DISP_BURST_STAT_EN
  ,
  output logic [31:0]              STAT_BURSTS,
  output logic [31:0]              STAT_STALL
`endif
);

  localparam logic [BurstLenWidth:0] LastBeatIdx = (BurstLenWidth+1)'(MaxBurstLen - 1);
  localparam logic [BurstLenWidth:0] BeatOne     = (BurstLenWidth+1)'(1);
  localparam logic [1:0]             RecDepth    = 2'(REC_FIFO_DEPTH);

  if (!burst_len_legal(MaxBurstLen)) begin : g_bad_len
    $error("MaxBurstLen must be in 1..256");
  end

  // ---------------------------------------------------------------------------
  // Accept / burst slicing
  // ---------------------------------------------------------------------------
  logic [BurstLenWidth:0] r_beat;       // beats accepted in the current burst
  logic                   r_rdy_en;     // holds SREADY low through reset
  logic [1:0]             w_rec_cnt;
  logic                   w_acc;
  logic                   w_burst_end;

  logic                   r_skid_vld;
  logic [DataWidth-1:0]   r_skid_data;
  logic                   r_skid_last;

  assign SREADY      = r_rdy_en && !r_skid_vld && (w_rec_cnt < RecDepth);
  assign w_acc       = SVALID && SREADY;
  // SLAST on the length-limit beat still yields a single burst end.
  assign w_burst_end = SLAST || (r_beat == LastBeatIdx);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rdy_en <= 1'b0;
      r_beat   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_acc) r_beat <= w_burst_end ? '0 : r_beat + BeatOne;
    end
  end

  // ---------------------------------------------------------------------------
  // W output register + skid
  // ---------------------------------------------------------------------------
  logic                 r_wvalid;
  logic                 r_wlast;
  logic [DataWidth-1:0] r_wdata;
  logic                 w_out_free;

  // Output register can take a beat this edge: empty, or draining now.
  assign w_out_free = !r_wvalid || WREADY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_wdata     <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        // SREADY is low while the skid is full, so no new beat competes here.
        r_wvalid   <= 1'b1;
        r_wdata    <= r_skid_data;
        r_wlast    <= r_skid_last;
        r_skid_vld <= 1'b0;
      end else if (w_acc) begin
        r_wvalid <= 1'b1;
        r_wdata  <= SDATA;
        r_wlast  <= w_burst_end;
      end else begin
        r_wvalid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= SDATA;
      r_skid_last <= w_burst_end;
    end
  end

  assign WVALID = r_wvalid;
  assign WDATA  = r_wdata;
  assign WLAST  = r_wlast;

  // ---------------------------------------------------------------------------
  // Burst-length records
  // ---------------------------------------------------------------------------
  logic                     w_rec_push;
  logic [BurstLenWidth-1:0] w_rec_blen;

  assign w_rec_push = w_acc && w_burst_end;
  assign w_rec_blen = r_beat[BurstLenWidth-1:0];

  disp_burst_rec_fifo #(
    .Width (BurstLenWidth)
  ) u_rec_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_rec_push),
    .i_data  (w_rec_blen),
    .o_valid (BVALID),
    .o_data  (BLEN),
    .i_ready (BREADY),
    .o_count (w_rec_cnt)
  );

`ifdef DISP_BURST_STAT_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_stall;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stat_bursts <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_rec_push && (r_stat_bursts != '1))
        r_stat_bursts <= r_stat_bursts + 32'd1;
      if (SVALID && !SREADY && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign STAT_BURSTS = r_stat_bursts;
  assign STAT_STALL  = r_stat_stall;
`endif

endmodule
